// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK_WAIT
   } uart_state_e;

   localparam int unsigned DEFAULT_DATA_BITS  = 8;
   localparam int unsigned DEFAULT_OVERSAMPLE = 16;
   localparam logic        IDLE_LEVEL         = 1'b1;

endpackage

// File: rtl/uart_sync_ff.sv
// Flop-chain synchronizer for an asynchronous single-bit input; all stages reset to RESET_VALUE.
module uart_sync_ff
   import uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VALUE = IDLE_LEVEL
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stages_q <= {SYNC_STAGES{RESET_VALUE}};
      end else begin
         stages_q <= {stages_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1-style UART receiver with mid-bit sampling, false-start rejection and break handling,
// paced by an OVERSAMPLE x baud sample_tick enable.
module uart_rx_oversampled
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS,
   parameter int unsigned OVERSAMPLE  = DEFAULT_OVERSAMPLE,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_tick,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 framing_error,
   output logic                 busy
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] BIT_DONE  = BW'(DATA_BITS);

   logic                 rx_s;
   uart_state_e          state_q, state_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 framing_error_q, framing_error_d;

   uart_sync_ff #(
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_VALUE(IDLE_LEVEL)
   ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (rx_in),
      .q    (rx_s)
   );

   always_comb begin
      state_d         = state_q;
      tick_cnt_d      = tick_cnt_q;
      bit_cnt_d       = bit_cnt_q;
      shift_d         = shift_q;
      data_out_d      = data_out_q;
      data_valid_d    = 1'b0;
      framing_error_d = 1'b0;

      if (sample_tick) begin
         unique case (state_q)
            IDLE: begin
               if (rx_s != IDLE_LEVEL) begin
                  state_d    = START;
                  tick_cnt_d = '0;
               end
            end
            START: begin
               if (tick_cnt_q == TICK_HALF) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  // A start bit that is gone by its centre was a glitch.
                  state_d    = (rx_s != IDLE_LEVEL) ? DATA : IDLE;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (tick_cnt_q == TICK_LAST) begin
                  shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                  tick_cnt_d = '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d = BIT_DONE;
                     state_d   = STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  if (rx_s == IDLE_LEVEL) begin
                     data_out_d   = shift_q;
                     data_valid_d = 1'b1;
                     state_d      = IDLE;
                  end else begin
                     framing_error_d = 1'b1;
                     state_d         = BREAK_WAIT;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            BREAK_WAIT: begin
               // Holding here turns a long break into a single framing error.
               if (rx_s == IDLE_LEVEL) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         tick_cnt_q      <= '0;
         bit_cnt_q       <= '0;
         shift_q         <= '0;
         data_out_q      <= '0;
         data_valid_q    <= 1'b0;
         framing_error_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         tick_cnt_q      <= tick_cnt_d;
         bit_cnt_q       <= bit_cnt_d;
         shift_q         <= shift_d;
         data_out_q      <= data_out_d;
         data_valid_q    <= data_valid_d;
         framing_error_q <= framing_error_d;
      end
   end

   assign data_out      = data_out_q;
   assign data_valid    = data_valid_q;
   assign framing_error = framing_error_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: vector table, hand-written corner sequences and
// randomized frames scored against a frame-level expectation queue.
module tb_uart_rx_oversampled;

   localparam int OVERSAMPLE = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       sample_tick;
   logic       rx_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       framing_error;
   logic       busy;

   uart_rx_oversampled #(
      .DATA_BITS  (8),
      .OVERSAMPLE (OVERSAMPLE),
      .SYNC_STAGES(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_tick  (sample_tick),
      .rx_in        (rx_in),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .framing_error(framing_error),
      .busy         (busy)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      bit         err;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      bit         stop;
      int         period;
      logic [7:0] exp_out;
      int         exp_valid;
      int         exp_fe;
   } vec_t;

   ev_t  ev_q[$];
   ev_t  exp_q[$];
   vec_t vecs[6];

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   tick_period = 1;
   int   div = 0;
   bit   tick_at_edge = 1'b0;
   bit   reset_at_edge = 1'b1;
   logic prev_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int count_ev(input bit err);
      int n = 0;
      foreach (ev_q[i]) if (ev_q[i].err == err) n++;
      return n;
   endfunction

   task automatic send_frame(input logic [7:0] d, input bit stop_bit, input int cpb);
      rx_in = 1'b0;
      repeat (cpb) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_in = d[i];
         repeat (cpb) @(negedge clk);
      end
      rx_in = stop_bit;
      repeat (cpb) @(negedge clk);
      rx_in = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Tick generator: one pulse every tick_period clocks.
   initial begin
      sample_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_period <= 1) begin
            div         = 0;
            sample_tick = 1'b1;
         end else begin
            div         = (div + 1 >= tick_period) ? 0 : div + 1;
            sample_tick = (div == 0);
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
      tick_at_edge  = sample_tick;
      reset_at_edge = reset;
   end

   // Event monitor plus invariants that hold on every cycle.
   initial forever begin
      @(negedge clk);
      if (data_valid === 1'b1 || framing_error === 1'b1) begin
         ev_q.push_back('{framing_error, data_out, cyc});
         check("valid_fe_exclusive", 32'(data_valid & framing_error), 32'(0));
         check("pulse_on_tick_edge", 32'(tick_at_edge), 32'(1));
      end
      if (busy !== prev_busy && !reset_at_edge)
         check("busy_moves_on_tick", 32'(tick_at_edge), 32'(1));
      prev_busy = busy;
   end

   initial begin
      int         busy_cnt;
      int         p;
      int         gap;
      bit         stop;
      logic [7:0] d;
      logic [7:0] last_good;

      vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1, 0};
      vecs[1] = '{8'h3C, 1'b0, 1, 8'hA5, 0, 1};
      vecs[2] = '{8'h81, 1'b1, 1, 8'h81, 1, 0};
      vecs[3] = '{8'hC3, 1'b1, 5, 8'hC3, 1, 0};
      vecs[4] = '{8'h7E, 1'b1, 2, 8'h7E, 1, 0};
      vecs[5] = '{8'h00, 1'b1, 3, 8'h00, 1, 0};

      reset = 1'b1;
      rx_in = 1'b1;
      idle(4);
      check("reset_data_out", 32'(data_out), 32'(0));
      check("reset_data_valid", 32'(data_valid), 32'(0));
      check("reset_framing_error", 32'(framing_error), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      reset = 1'b0;
      idle(4);
      check("idle_busy", 32'(busy), 32'(0));

      for (int i = 0; i < 6; i++) begin
         ev_q.delete();
         tick_period = vecs[i].period;
         idle(2 * OVERSAMPLE * vecs[i].period);
         send_frame(vecs[i].data, vecs[i].stop, OVERSAMPLE * vecs[i].period);
         idle(2 * OVERSAMPLE * vecs[i].period);
         check($sformatf("vec%0d_valid_count", i), 32'(count_ev(1'b0)), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_fe_count", i), 32'(count_ev(1'b1)), 32'(vecs[i].exp_fe));
         check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].exp_out));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(0));
         foreach (ev_q[k])
            check($sformatf("vec%0d_event_data", i), 32'(ev_q[k].data), 32'(vecs[i].exp_out));
      end

      // Back-to-back frames with zero idle gap.
      ev_q.delete();
      tick_period = 1;
      idle(32);
      send_frame(8'h00, 1'b1, OVERSAMPLE);
      send_frame(8'hFF, 1'b1, OVERSAMPLE);
      idle(48);
      check("b2b_valid_count", 32'(count_ev(1'b0)), 32'(2));
      check("b2b_fe_count", 32'(count_ev(1'b1)), 32'(0));
      if (ev_q.size() == 2) begin
         check("b2b_first", 32'(ev_q[0].data), 32'(8'h00));
         check("b2b_second", 32'(ev_q[1].data), 32'(8'hFF));
         check("b2b_spacing", 32'(ev_q[1].cyc - ev_q[0].cyc), 32'(10 * OVERSAMPLE));
      end

      // Bad stop bit followed by a long break, then a good frame.
      ev_q.delete();
      send_frame(8'h3C, 1'b0, OVERSAMPLE);
      rx_in = 1'b0;
      idle(100);
      rx_in = 1'b1;
      idle(32);
      send_frame(8'h81, 1'b1, OVERSAMPLE);
      idle(32);
      check("break_fe_count", 32'(count_ev(1'b1)), 32'(1));
      check("break_valid_count", 32'(count_ev(1'b0)), 32'(1));
      if (ev_q.size() == 2) begin
         check("break_fe_first", 32'(ev_q[0].err), 32'(1));
         check("break_data_held", 32'(ev_q[0].data), 32'(8'hFF));
         check("break_next_byte", 32'(ev_q[1].data), 32'(8'h81));
      end
      check("break_data_out", 32'(data_out), 32'(8'h81));

      // False start: four low clocks, then high.
      ev_q.delete();
      busy_cnt = 0;
      rx_in    = 1'b0;
      for (int k = 0; k < 44; k++) begin
         @(negedge clk);
         if (k == 3) rx_in = 1'b1;
         if (busy === 1'b1) busy_cnt++;
      end
      check("false_start_busy_cycles", 32'(busy_cnt), 32'(8));
      check("false_start_no_events", 32'(ev_q.size()), 32'(0));

      // Reset during data bit 4 of 0x5A; the transmitter abandons the frame.
      ev_q.delete();
      d     = 8'h5A;
      rx_in = 1'b0;
      idle(OVERSAMPLE);
      for (int i = 0; i < 4; i++) begin
         rx_in = d[i];
         idle(OVERSAMPLE);
      end
      rx_in = d[4];
      idle(OVERSAMPLE / 2);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_data_out", 32'(data_out), 32'(0));
      check("midreset_valid", 32'(data_valid), 32'(0));
      check("midreset_fe", 32'(framing_error), 32'(0));
      check("midreset_busy", 32'(busy), 32'(0));
      reset = 1'b0;
      rx_in = 1'b1;
      idle(64);
      check("midreset_no_events", 32'(ev_q.size()), 32'(0));
      send_frame(8'h5A, 1'b1, OVERSAMPLE);
      idle(32);
      check("midreset_recover_count", 32'(count_ev(1'b0)), 32'(1));
      check("midreset_recover_data", 32'(data_out), 32'(8'h5A));

      // Randomized frames: a good stop yields the byte, a bad one an error with data_out held.
      ev_q.delete();
      exp_q.delete();
      last_good = 8'h5A;
      for (int f = 0; f < 24; f++) begin
         p    = $urandom_range(1, 3);
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
         tick_period = p;
         if (stop) last_good = d;
         exp_q.push_back('{!stop, last_good, 0});
         send_frame(d, stop, OVERSAMPLE * p);
         idle(gap * OVERSAMPLE * p);
      end
      idle(4 * OVERSAMPLE * 3);
      check("rand_event_count", 32'(ev_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
         check($sformatf("rand%0d_kind", i), 32'(ev_q[i].err), 32'(exp_q[i].err));
         check($sformatf("rand%0d_data", i), 32'(ev_q[i].data), 32'(exp_q[i].data));
      end
      check("rand_final_data_out", 32'(data_out), 32'(last_good));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- Serial receiver for the 8N1 frames produced by our UART transmitter: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1); idle line is high.
- Runs on the single system clock and is paced by a 16x-baud sample_tick enable from the baud generator. The line is never used as a clock.
- Recovers bytes with mid-bit sampling, rejects false starts, reports framing errors.
- Sits between the rx_in pin and the host-side consumer.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be even and >= 4.
- SYNC_STAGES, 2, flops in the rx_in synchronizer (>= 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_tick  input  1  one-clk-wide enable at OVERSAMPLE x baud rate.
- rx_in  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  last correctly framed byte; holds until the next good frame.
- data_valid  output  1  one-clk pulse when data_out is updated.
- framing_error  output  1  one-clk pulse when the stop bit samples 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Synchronizer: rx_in passes through SYNC_STAGES flops, all reset to 1. The last flop is rx_s. All decisions use rx_s and are evaluated only on clk edges where sample_tick=1.
- Reset values: data_out=0, data_valid=0, framing_error=0, busy=0, state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0.
- Reset asserted mid-frame aborts the frame on that edge. No valid or error pulse is produced, and the partial byte is discarded.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits.
  - bit_cnt is $clog2(DATA_BITS+1) bits.
  - Counters never wrap silently; each terminal value is an explicit transition.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: on each tick, if tick_cnt==OVERSAMPLE/2-1, sample rx_s:
  - rx_s=0: go to DATA with tick_cnt=0 and bit_cnt=0.
  - rx_s=1: false start (glitch); return to IDLE with no output.
  - Otherwise increment tick_cnt.
- DATA: on each tick, if tick_cnt==OVERSAMPLE-1, sample at bit centre:
  - Shift rx_s in at the MSB and shift right (LSB-first reception); reset tick_cnt to 0 and increment bit_cnt.
  - When bit_cnt reaches DATA_BITS, go to STOP.
  - Otherwise increment tick_cnt.
- STOP: on a tick with tick_cnt==OVERSAMPLE-1, sample:
  - rx_s=1: data_out <= shift register and data_valid=1 on that edge; go to IDLE.
  - rx_s=0: framing_error=1, data_out unchanged; go to BREAK_WAIT.
- BREAK_WAIT: stay until a tick with rx_s=1, then go to IDLE. A held-low line (break) therefore gives exactly one framing_error, not a stream of errors.
- data_valid and framing_error are registered, high for exactly one clk cycle, and never asserted together.
- Timing: the stop-bit decision falls (DATA_BITS+1)*OVERSAMPLE + OVERSAMPLE/2 ticks after the start-detect tick, i.e. mid stop bit. IDLE is re-entered there, so back-to-back frames with zero idle gap are received.
- No buffering (overrun): a new good frame overwrites data_out. The consumer must capture data_out on the data_valid cycle.
- sample_tick=0 freezes all state and counters; rx_in may change freely between ticks.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK_WAIT}
  - default DATA_BITS and OVERSAMPLE constants
  - the IDLE_LEVEL=1 constant
- One sub-module, uart_sync_ff: parameterised SYNC_STAGES flop chain with reset value 1. It is reusable for other asynchronous inputs.

Test Plan:
- Clean frame: sample_tick tied 1, frame 0xA5 driven at 16 clk/bit. Required: data_valid pulses once, data_out=0xA5, busy falls, framing_error stays 0.
- Back-to-back: 0x00 then 0xFF, zero idle gap. Required: two data_valid pulses, values 0x00 then 0xFF, spacing 160 clk.
- False start: rx_in low for 4 ticks, then high. Required: busy high for 8 ticks, then IDLE; no data_valid or framing_error.
- Framing error / break: 0x3C with stop bit 0, line then held low 100 ticks, then high, then a valid 0x81. Required: exactly one framing_error pulse, data_out retains the previous value, then data_valid with 0x81.
- Reset mid-frame: reset asserted 1 clk during bit 4 of 0x5A. Required: outputs at reset values the next cycle, no pulse for the aborted frame; a following 0x5A is received correctly.
- Sparse ticks: sample_tick every 5th clk, frame 0xC3. Required: data_out=0xC3, state frozen on non-tick cycles.
